// File: rtl/exc_ctrl.sv
// exc_ctrl - exception/interrupt sequencer between the MEM stage and cp0.
//
// Picks the highest-priority event among interrupts, the MEM-stage exception
// flags and ERET. It reports that event to cp0 as a one-cycle exccode pulse,
// flushes the pipeline for FLUSH_CYC cycles, and then hands the cp0 handler
// address to IF through a valid/ready redirect handshake.
//
// Build option:
//   EXC_INT_SYNC_EN  defined   : int_i goes through a two-flop synchroniser
//                                (2 cycles from int_i to int_pend).
//                    undefined : a single register stage (1 cycle).
//
// Parameters:
//   FLUSH_CYC         number of cycles flush_o is high, COMMIT included (1..7)
//
// Ports:
//   cpu_clk_50M       clock
//   cpu_rst_n         asynchronous active-low reset
//   int_i[5:0]        raw hardware interrupts (IM[15:10])
//   sw_ip_i[1:0]      software interrupt pending bits, Cause[9:8]
//   status_i[31:0]    cp0 Status (IE=bit0, EXL=bit1, IM=bits15:8)
//   mem_valid_i       a valid instruction is in MEM
//   mem_pc_i          MEM-stage PC
//   mem_in_delay_i    the MEM instruction sits in a delay slot
//   mem_exc_i[6:0]    {AdES, AdEL data, Bp, Sys, Ov, RI, AdEL fetch}
//   mem_eret_i        the MEM instruction is ERET
//   mem_daddr_i       data address of the MEM instruction
//   cp0_excaddr_i     handler address (or EPC for ERET) from cp0
//   redirect_ready_i  IF accepts the redirect
//   exccode_o         event code to cp0; NONE (10h) outside COMMIT
//   exc_pc_o          PC of the excepting instruction
//   in_delay_o        delay-slot flag of the excepting instruction
//   badvaddr_o        faulting address
//   flush_o           flushes IF..MEM
//   stall_o           freezes the pipeline
//   redirect_valid_o  redirect request to IF
//   redirect_pc_o     new fetch PC

module exc_ctrl #(
    parameter int FLUSH_CYC = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic [5:0]  int_i,
    input  logic [1:0]  sw_ip_i,
    input  logic [31:0] status_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_i,
    input  logic [6:0]  mem_exc_i,
    input  logic        mem_eret_i,
    input  logic [31:0] mem_daddr_i,
    input  logic [31:0] cp0_excaddr_i,
    input  logic        redirect_ready_i,
    output logic [4:0]  exccode_o,
    output logic [31:0] exc_pc_o,
    output logic        in_delay_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ERET = 5'h11;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMMIT   = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    // COMMIT itself is the first flush cycle, so the FLUSH counter covers
    // the remaining FLUSH_CYC-1 cycles and runs down to 0.
    localparam logic [2:0] FLUSH_LOAD = (FLUSH_CYC > 1) ? 3'(FLUSH_CYC - 2) : 3'd0;

    logic [1:0]  state;
    logic [2:0]  flush_cnt;
    logic [5:0]  int_s;
    logic        int_pend;
    logic [4:0]  code_p0;
    logic [31:0] badv_p0;
    logic        take_p0;
    logic [4:0]  code_p1;
    logic [31:0] pc_p1;
    logic        delay_p1;
    logic [31:0] badv_p1;
    logic [31:0] redirect_pc;

    // Only IE, EXL and IM are used from Status.
    logic        status_unused;
    assign status_unused = ^{status_i[31:16], status_i[7:2]};

    // ---- interrupt input registering ----
`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_meta;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            int_meta <= '0;
            int_s    <= '0;
        end else begin
            int_meta <= int_i;
            int_s    <= int_meta;
        end
    end
`else
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            int_s <= '0;
        end else begin
            int_s <= int_i;
        end
    end
`endif

    assign int_pend = status_i[0] & ~status_i[1] &
                      (|({int_s, sw_ip_i} & status_i[15:8]));

    // ---- stage p0: priority selection in MEM ----
    always_comb begin
        code_p0 = EXC_NONE;
        badv_p0 = '0;
        if (int_pend) begin
            code_p0 = EXC_INT;
        end else if (mem_exc_i[0]) begin
            code_p0 = EXC_ADEL;
            badv_p0 = mem_pc_i;
        end else if (mem_exc_i[1]) begin
            code_p0 = EXC_RI;
        end else if (mem_exc_i[2]) begin
            code_p0 = EXC_OV;
        end else if (mem_exc_i[3]) begin
            code_p0 = EXC_SYS;
        end else if (mem_exc_i[4]) begin
            code_p0 = EXC_BP;
        end else if (mem_exc_i[5]) begin
            code_p0 = EXC_ADEL;
            badv_p0 = mem_daddr_i;
        end else if (mem_exc_i[6]) begin
            code_p0 = EXC_ADES;
            badv_p0 = mem_daddr_i;
        end else if (mem_eret_i) begin
            code_p0 = EXC_ERET;
        end
    end

    assign take_p0 = mem_valid_i && (state == S_IDLE) && (code_p0 != EXC_NONE);

    // ---- stage p1: sequencing and captured event ----
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state       <= S_IDLE;
            flush_cnt   <= '0;
            code_p1     <= EXC_NONE;
            pc_p1       <= '0;
            delay_p1    <= 1'b0;
            badv_p1     <= '0;
            redirect_pc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_p0) begin
                        code_p1  <= code_p0;
                        pc_p1    <= mem_pc_i;
                        delay_p1 <= mem_in_delay_i;
                        badv_p1  <= badv_p0;
                        state    <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // cp0 has just seen exccode, so its handler address
                    // (or EPC for ERET) is valid here.
                    redirect_pc <= cp0_excaddr_i;
                    flush_cnt   <= FLUSH_LOAD;
                    state       <= (FLUSH_CYC > 1) ? S_FLUSH : S_REDIRECT;
                end
                S_FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state <= S_REDIRECT;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign exccode_o        = (state == S_COMMIT) ? code_p1 : EXC_NONE;
    assign exc_pc_o         = pc_p1;
    assign in_delay_o       = delay_p1;
    assign badvaddr_o       = badv_p1;
    assign flush_o          = (state == S_COMMIT) || (state == S_FLUSH);
    assign stall_o          = (state != S_IDLE) || take_p0;
    assign redirect_valid_o = (state == S_REDIRECT);
    assign redirect_pc_o    = redirect_pc;

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer sitting between the MEM stage and `cp0`. It prioritises the MEM-stage exception vector, ERET and masked interrupts, and presents exactly one event per exception to `cp0` as a one-cycle `exccode` pulse. It then sequences the pipeline flush, captures the CP0 handler address and hands it to IF through a valid/ready redirect handshake.

## Interface
Parameters:
- `FLUSH_CYC`, 2: cycles `flush_o` stays high, counting the COMMIT cycle; legal range 1..7.

Ports, clock and reset first:
- `cpu_clk_50M`, in, 1: the only clock.
- `cpu_rst_n`, in, 1: reset, asynchronous, active-low.
- `int_i`, in, 6: raw hardware interrupts, mapped to IM[15:10].
- `sw_ip_i`, in, 2: Cause[9:8] from `cp0`.
- `status_i`, in, 32: Status from `cp0`. Bit 0 is IE, bit 1 is EXL, bits 15:8 are IM.
- `mem_valid_i`, in, 1: a valid instruction is in MEM.
- `mem_pc_i`, in, 32: MEM-stage PC.
- `mem_in_delay_i`, in, 1: the MEM instruction is in a delay slot.
- `mem_exc_i`, in, 7: exception flags. [0] AdEL fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL data, [6] AdES.
- `mem_eret_i`, in, 1: the MEM instruction is ERET.
- `mem_daddr_i`, in, 32: data address of the MEM instruction.
- `cp0_excaddr_i`, in, 32: handler address from `cp0`.
- `redirect_ready_i`, in, 1: IF accepts the redirect.
- `exccode_o`, out, 5: to `cp0` `exccode_i`.
- `exc_pc_o`, out, 32: to `cp0` `pc_i`.
- `in_delay_o`, out, 1: to `cp0` `in_delay_i`.
- `badvaddr_o`, out, 32: faulting address.
- `flush_o`, out, 1: flushes IF through MEM.
- `stall_o`, out, 1: freezes the pipeline.
- `redirect_valid_o`, out, 1: redirect request to IF.
- `redirect_pc_o`, out, 32: new fetch PC.

## Operation
Exception codes:
- INT = 00h, ADEL = 04h, ADES = 05h, SYS = 08h, BP = 09h, RI = 0Ah, OV = 0Ch.
- NONE = 10h, ERET = 11h.

Interrupt detection:
- `int_pend = IE & ~EXL & |({int_s, sw_ip_i} & IM)`, where `int_s` is the registered copy of `int_i`.
- Interrupts are level-sensitive and never latched by this block.

Priority, highest first: INT, AdEL fetch, RI, Ov, Sys, Bp, AdEL data, AdES, ERET. ERET is taken only when no exception or interrupt is present.

An event qualifies only when `mem_valid_i` is high and the state is IDLE. All inputs are ignored in every other state.

State machine: IDLE → COMMIT → FLUSH → REDIRECT → IDLE.
- **IDLE:**
  - On a qualifying event, register code, `mem_pc_i`, `mem_in_delay_i` and badvaddr, then go to COMMIT.
  - badvaddr is `mem_pc_i` for AdEL fetch, `mem_daddr_i` for AdEL/AdES data, and 0 otherwise.
- **COMMIT:**
  - `exccode_o` carries the registered code; `exc_pc_o`, `in_delay_o` and `badvaddr_o` carry the registered values.
  - `cp0_excaddr_i` is captured into `redirect_pc_o` at the end of this cycle.
  - Go to FLUSH if `FLUSH_CYC` > 1, else to REDIRECT.
- **FLUSH:** a down-counter loaded with `FLUSH_CYC-2` on COMMIT exit; go to REDIRECT when it reaches 0.
- **REDIRECT:** `redirect_valid_o` is 1; go to IDLE on `redirect_valid_o & redirect_ready_i`.

Output rules:
- `exccode_o` is NONE in every cycle except COMMIT.
- `flush_o` is 1 in COMMIT and FLUSH only.
- `stall_o` is 1 when the state is not IDLE, or combinationally in IDLE when an event qualifies.
- `redirect_pc_o` holds its value until the next COMMIT.

## Timing
- The event is sampled at edge T. COMMIT occupies cycle T+1, with `flush_o` high in cycles T+1 .. T+`FLUSH_CYC`.
- REDIRECT starts at cycle T+`FLUSH_CYC`+1. Each cycle of `redirect_ready_i` low extends REDIRECT by one cycle.
- Minimum back-to-back spacing: a second event qualifies in the first IDLE cycle after the handshake.
- Simultaneous exception flag and ERET: the exception wins. Several flags at once: only the highest-priority flag is reported.
- Interrupt while the state is not IDLE: ignored; it is taken in IDLE if it is still pending and unmasked.
- Reset: asynchronous, any state → IDLE.
  - `exccode_o` = 10h; `flush_o`, `stall_o`, `redirect_valid_o` and `in_delay_o` = 0.
  - `exc_pc_o`, `badvaddr_o` and `redirect_pc_o` = 0.
  - The interrupt synchronisers clear to 0.

## Configuration
`EXC_INT_SYNC_EN`:
- Defined: `int_i` passes through a two-flop synchroniser, so there are 2 cycles from `int_i` to `int_pend`.
- Undefined: a single register stage, so there is 1 cycle of latency.
- Software interrupts (`sw_ip_i`) are unregistered in both builds.

## Test plan
- Ov at PC 0xBFC00100, `FLUSH_CYC`=2, ready tied 1:
  - `exccode_o`=0Ch for exactly one cycle at T+1, `exc_pc_o`=0xBFC00100.
  - `flush_o` high at T+1 and T+2, redirect at T+3 with `cp0_excaddr_i` captured at T+1, IDLE at T+4.
- AdES with `mem_daddr_i`=0x80000003, `in_delay` set: `exccode_o`=05h, `badvaddr_o`=0x80000003, `in_delay_o`=1.
- RI+Ov+ERET together → 0Ah only. ERET alone → 11h, and `redirect_pc_o` equals the `cp0_excaddr_i` value driven (EPC).
- `int_i`[0]=1 with IE=1, IM[10]=1, EXL=0:
  - With the macro, INT is committed 2 cycles later (1 cycle without the macro).
  - With EXL=1 there is no event.
- Hold `redirect_ready_i` low for 5 cycles: `redirect_valid_o` stays high, and new flags during those cycles are ignored.
- Deassert `cpu_rst_n` during FLUSH: all outputs take their reset values immediately; the next event sequences normally.
